// File: rtl/l2_cache_pkg.sv
// Shared types and constants for the L2 lookup controller: FSM states, address field
// widths, replacement LFSR constants and address slice helpers for the default geometry.
package l2_cache_pkg;

   localparam int WAYS_DEFAULT       = 8;
   localparam int INDEX_BITS_DEFAULT = 14;
   localparam int TAG_BITS_DEFAULT   = 10;
   localparam int OFFSET_BITS        = 6;
   localparam int WAY_BITS           = $clog2(WAYS_DEFAULT);
   localparam int ADDR_BITS_DEFAULT  = TAG_BITS_DEFAULT + INDEX_BITS_DEFAULT + OFFSET_BITS;

   // x^16 + x^14 + x^13 + x^11 + 1 maps to feedback bits 15, 13, 12 and 10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_COMPARE,
      ST_MISS_REQ,
      ST_MISS_WAIT,
      ST_FILL,
      ST_RESP
   } state_t;

   function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

   function automatic logic [TAG_BITS_DEFAULT-1:0] addrTag(input logic [ADDR_BITS_DEFAULT-1:0] addr);
      return addr[ADDR_BITS_DEFAULT-1 -: TAG_BITS_DEFAULT];
   endfunction

   function automatic logic [INDEX_BITS_DEFAULT-1:0] addrIndex(input logic [ADDR_BITS_DEFAULT-1:0] addr);
      return addr[OFFSET_BITS +: INDEX_BITS_DEFAULT];
   endfunction

   function automatic logic [ADDR_BITS_DEFAULT-1:0] lineAddr(input logic [ADDR_BITS_DEFAULT-1:0] addr);
      return {addr[ADDR_BITS_DEFAULT-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/l2_victim_select.sv
// Victim way choice: lowest invalid way wins, otherwise the replacement policy.
// LFSR_REPL_EN selects a free-running 16-bit LFSR; otherwise a round-robin counter is used.
module l2_victim_select
   import l2_cache_pkg::*;
#(
   parameter int WAYS = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [WAYS-1:0]         i_valid,
   input  logic                    i_advance,
   output logic [$clog2(WAYS)-1:0] o_victim
);

   localparam int WB = $clog2(WAYS);

   logic [WB-1:0] w_firstInvalid;
   logic          w_anyInvalid;
   logic [WB-1:0] w_policyWay;

   // Scanning from the top way down leaves the lowest invalid way as the winner
   always_comb begin
      w_firstInvalid = '0;
      w_anyInvalid   = 1'b0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!i_valid[i]) begin
            w_firstInvalid = WB'(i);
            w_anyInvalid   = 1'b1;
         end
      end
   end

`ifdef LFSR_REPL_EN
   logic [15:0] r_lfsr;
   logic        w_unusedAdvance;

   // The LFSR free-runs, so the advance strobe has no role in this build
   assign w_unusedAdvance = i_advance;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= lfsrNext(r_lfsr);
      end
   end

   assign w_policyWay = r_lfsr[WB-1:0];
`else
   logic [WB-1:0] r_rrCount;

   // WAYS is a power of two, so natural overflow gives the WAYS-1 -> 0 wrap
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rrCount <= '0;
      end else if (i_advance) begin
         r_rrCount <= r_rrCount + WB'(1);
      end
   end

   assign w_policyWay = r_rrCount;
`endif

   assign o_victim = w_anyInvalid ? w_firstInvalid : w_policyWay;

endmodule

// File: rtl/l2_lookup_ctrl.sv
// Single-outstanding L2 read lookup sequencer: tag read, hit sample, miss fill and response.
// Build option LFSR_REPL_EN switches the victim policy from round-robin to a 16-bit LFSR.
module l2_lookup_ctrl #(
   parameter int WAYS        = 8,
   parameter int INDEX_BITS  = 14,
   parameter int TAG_BITS    = 10,
   parameter int OFFSET_BITS = l2_cache_pkg::OFFSET_BITS,
   parameter int ADDR_BITS   = TAG_BITS + INDEX_BITS + OFFSET_BITS
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_BITS-1:0]    req_addr,
   output logic                    arr_rd_en,
   output logic [INDEX_BITS-1:0]   arr_index,
   output logic                    arr_wr_en,
   output logic [$clog2(WAYS)-1:0] arr_wr_way,
   output logic [TAG_BITS-1:0]     arr_wr_tag,
   input  logic [WAYS-1:0]         arr_valid,
   output logic [TAG_BITS-1:0]     hd_addr_tag,
   input  logic                    hd_hit,
   input  logic [$clog2(WAYS)-1:0] hd_way,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic [ADDR_BITS-1:0]    mem_req_addr,
   input  logic                    mem_fill_valid,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic                    resp_hit,
   output logic [$clog2(WAYS)-1:0] resp_way
);

   import l2_cache_pkg::*;

   localparam int WB = $clog2(WAYS);

   state_t               r_state;
   logic [ADDR_BITS-1:0] r_addr;
   logic [WB-1:0]        r_victim;
   logic                 r_usedPolicy;
   logic                 r_reqReady;
   logic                 r_rdEn;
   logic                 r_wrEn;
   logic                 r_memReqValid;
   logic                 r_respValid;
   logic                 r_respHit;
   logic [WB-1:0]        r_respWay;

   logic [WB-1:0]        w_victim;
   logic                 w_advance;

   // Only fills whose victim came from the policy (set was full) move the replacement state
   assign w_advance = (r_state == ST_FILL) && r_usedPolicy;

   l2_victim_select #(
      .WAYS(WAYS)
   ) u_victimSelect (
      .clock    (clock),
      .reset    (reset),
      .i_valid  (arr_valid),
      .i_advance(w_advance),
      .o_victim (w_victim)
   );

   // Every output is a register or a slice of the captured address, so nothing glitches
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_addr        <= '0;
         r_victim      <= '0;
         r_usedPolicy  <= 1'b0;
         r_reqReady    <= 1'b1;
         r_rdEn        <= 1'b0;
         r_wrEn        <= 1'b0;
         r_memReqValid <= 1'b0;
         r_respValid   <= 1'b0;
         r_respHit     <= 1'b0;
         r_respWay     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_addr     <= req_addr;
                  r_reqReady <= 1'b0;
                  r_rdEn     <= 1'b1;
                  r_state    <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               r_rdEn  <= 1'b0;
               r_state <= ST_COMPARE;
            end
            ST_COMPARE: begin
               if (hd_hit) begin
                  r_respValid <= 1'b1;
                  r_respHit   <= 1'b1;
                  r_respWay   <= hd_way;
                  r_state     <= ST_RESP;
               end else begin
                  r_victim      <= w_victim;
                  r_usedPolicy  <= &arr_valid;
                  r_memReqValid <= 1'b1;
                  r_state       <= ST_MISS_REQ;
               end
            end
            ST_MISS_REQ: begin
               if (mem_req_ready) begin
                  r_memReqValid <= 1'b0;
                  r_state       <= ST_MISS_WAIT;
               end
            end
            ST_MISS_WAIT: begin
               if (mem_fill_valid) begin
                  r_wrEn  <= 1'b1;
                  r_state <= ST_FILL;
               end
            end
            ST_FILL: begin
               r_wrEn      <= 1'b0;
               r_respValid <= 1'b1;
               r_respHit   <= 1'b0;
               r_respWay   <= r_victim;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  r_respValid <= 1'b0;
                  r_respHit   <= 1'b0;
                  r_respWay   <= '0;
                  r_reqReady  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_reqReady <= 1'b1;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready     = r_reqReady;
   assign arr_rd_en     = r_rdEn;
   assign arr_index     = r_addr[OFFSET_BITS +: INDEX_BITS];
   assign arr_wr_en     = r_wrEn;
   assign arr_wr_way    = r_victim;
   assign arr_wr_tag    = r_addr[ADDR_BITS-1 -: TAG_BITS];
   assign hd_addr_tag   = r_addr[ADDR_BITS-1 -: TAG_BITS];
   assign mem_req_valid = r_memReqValid;
   assign mem_req_addr  = {r_addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   assign resp_valid    = r_respValid;
   assign resp_hit      = r_respHit;
   assign resp_way      = r_respWay;

endmodule

// File: tb/tb_l2_lookup_ctrl.sv
// Scoreboard bench for l2_lookup_ctrl: hit path, invalid-way miss, replacement policy
// (round-robin, or LFSR when LFSR_REPL_EN is defined), back-pressure and mid-access reset.
module tb_l2_lookup_ctrl;

   localparam logic [15:0] REF_SEED = 16'hACE1;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [29:0] req_addr = '0;
   logic        arr_rd_en;
   logic [13:0] arr_index;
   logic        arr_wr_en;
   logic [2:0]  arr_wr_way;
   logic [9:0]  arr_wr_tag;
   logic [7:0]  arr_valid = '0;
   logic [9:0]  hd_addr_tag;
   logic        hd_hit = 1'b0;
   logic [2:0]  hd_way = '0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [29:0] mem_req_addr;
   logic        mem_fill_valid = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic        resp_hit;
   logic [2:0]  resp_way;

   always #5 clock = ~clock;

   l2_lookup_ctrl dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .arr_rd_en     (arr_rd_en),
      .arr_index     (arr_index),
      .arr_wr_en     (arr_wr_en),
      .arr_wr_way    (arr_wr_way),
      .arr_wr_tag    (arr_wr_tag),
      .arr_valid     (arr_valid),
      .hd_addr_tag   (hd_addr_tag),
      .hd_hit        (hd_hit),
      .hd_way        (hd_way),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_fill_valid(mem_fill_valid),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_hit      (resp_hit),
      .resp_way      (resp_way)
   );

   typedef struct {
      logic        hit;
      logic [2:0]  way;
      int          wrCount;
      logic [9:0]  tag;
      logic [29:0] memAddr;
   } exp_t;

   typedef struct {
      logic        acceptReady;
      int          respCycle;
      logic        hit;
      logic [2:0]  way;
      int          rdCount;
      logic [13:0] rdIndex;
      logic [9:0]  hdTag;
      int          wrCount;
      logic [2:0]  wrWay;
      logic [9:0]  wrTag;
      logic        memSeen;
      logic [29:0] memAddr;
      logic        memStable;
      logic        respStable;
      logic        readyLowOk;
      logic        readyAfter;
      logic        respValidAfter;
      logic        timedOut;
   } obs_t;

   exp_t expQ[$];
   int   checkCount = 0;
   int   passCount  = 0;

   // Reference LFSR, independent of the design, stepping on the same edges
   logic [15:0] refLfsr;

   function automatic logic [15:0] refStep(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   always @(posedge clock) begin
      if (reset) refLfsr <= REF_SEED;
      else       refLfsr <= refStep(refLfsr);
   end

   // Drives one request and services memory/response handshakes, recording what it saw
   task automatic applyStimulus(input logic [29:0] addr, input logic hit, input logic [2:0] hdWay,
                                input logic [7:0] validVec, input int memStall, input int respStall,
                                output obs_t o);
      int c, lookupAt, memStallCnt, respStallCnt;
      bit memDone, fillSent, respSeen, done;
      o = '{default: 0};
      o.memStable = 1'b1; o.respStable = 1'b1; o.readyLowOk = 1'b1;
      c = 0; lookupAt = -1; memStallCnt = 0; respStallCnt = 0;
      memDone = 0; fillSent = 0; respSeen = 0; done = 0;
      @(negedge clock);
      o.acceptReady = req_ready;
      req_valid = 1'b1;
      req_addr  = addr;
      while (!done && c < 200) begin
         @(negedge clock);
         c++;
         req_valid = 1'b0;
         if (req_ready !== 1'b0) o.readyLowOk = 1'b0;
         if (arr_rd_en === 1'b1) begin
            o.rdCount++;
            o.rdIndex = arr_index;
            if (lookupAt < 0) begin
               lookupAt  = c;
               hd_hit    = hit;
               hd_way    = hdWay;
               arr_valid = validVec;
            end
         end
         if (lookupAt >= 0 && c == lookupAt + 1) o.hdTag = hd_addr_tag;
         if (lookupAt >= 0 && c == lookupAt + 2) begin
            hd_hit    = ~hit;
            hd_way    = ~hdWay;
            arr_valid = ~validVec;
         end
         if (arr_wr_en === 1'b1) begin
            o.wrCount++;
            o.wrWay = arr_wr_way;
            o.wrTag = arr_wr_tag;
         end
         if (mem_req_valid === 1'b1) begin
            if (!o.memSeen) begin
               o.memSeen = 1'b1;
               o.memAddr = mem_req_addr;
            end else if (mem_req_addr !== o.memAddr) begin
               o.memStable = 1'b0;
            end
            if (memStallCnt < memStall) begin
               mem_req_ready  = 1'b0;
               mem_fill_valid = memStallCnt[0];
               memStallCnt++;
            end else begin
               mem_req_ready  = 1'b1;
               mem_fill_valid = 1'b0;
               memDone = 1;
            end
         end else if (memDone && !fillSent) begin
            mem_req_ready  = 1'b0;
            mem_fill_valid = 1'b1;
            fillSent = 1;
         end else begin
            mem_fill_valid = 1'b0;
         end
         if (resp_valid === 1'b1) begin
            if (!respSeen) begin
               respSeen    = 1;
               o.respCycle = c;
               o.hit       = resp_hit;
               o.way       = resp_way;
            end else if (resp_hit !== o.hit || resp_way !== o.way) begin
               o.respStable = 1'b0;
            end
            if (respStallCnt < respStall) begin
               resp_ready = 1'b0;
               respStallCnt++;
            end else begin
               resp_ready = 1'b1;
               done = 1;
            end
         end
      end
      if (!done) begin
         o.timedOut = 1'b1;
      end else begin
         @(negedge clock);
         o.readyAfter     = req_ready;
         o.respValidAfter = resp_valid;
      end
      resp_ready = 1'b0; mem_req_ready = 1'b0; mem_fill_valid = 1'b0;
      hd_hit = 1'b0; arr_valid = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      checkCount++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else passCount++;
      checkCount++; if (arr_rd_en !== 1'b0 || arr_wr_en !== 1'b0) $display("FAIL reset_arr_strobes: got rd=%b wr=%b want 0", arr_rd_en, arr_wr_en); else passCount++;
      checkCount++; if (mem_req_valid !== 1'b0) $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); else passCount++;
      checkCount++; if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_way !== 3'd0) $display("FAIL reset_resp: got v=%b h=%b w=%0d want 0", resp_valid, resp_hit, resp_way); else passCount++;
      checkCount++; if (mem_req_addr !== 30'd0 || arr_index !== 14'd0) $display("FAIL reset_addr: got mem=%h idx=%h want 0", mem_req_addr, arr_index); else passCount++;
   endtask

   task automatic test_hit();
      obs_t o;
      exp_t e;
      logic [29:0] a;
      a = 30'h0004_0040;
      expQ.push_back('{hit: 1'b1, way: 3'd5, wrCount: 0, tag: a[29:20], memAddr: 30'd0});
      applyStimulus(a, 1'b1, 3'd5, 8'hFF, 0, 0, o);
      e = expQ.pop_front();
      checkCount++; if (o.timedOut !== 1'b0) $display("FAIL hit_timeout: no response within budget"); else passCount++;
      checkCount++; if (o.acceptReady !== 1'b1) $display("FAIL hit_accept_ready: got %b want 1", o.acceptReady); else passCount++;
      checkCount++; if (o.respCycle !== 3) $display("FAIL hit_latency: got %0d want 3", o.respCycle); else passCount++;
      checkCount++; if (o.hit !== e.hit || o.way !== e.way) $display("FAIL hit_resp: got h=%b w=%0d want h=%b w=%0d", o.hit, o.way, e.hit, e.way); else passCount++;
      checkCount++; if (o.rdCount !== 1 || o.rdIndex !== a[19:6]) $display("FAIL hit_lookup: got rd=%0d idx=%h want 1 %h", o.rdCount, o.rdIndex, a[19:6]); else passCount++;
      checkCount++; if (o.hdTag !== e.tag) $display("FAIL hit_hd_tag: got %h want %h", o.hdTag, e.tag); else passCount++;
      checkCount++; if (o.wrCount !== e.wrCount || o.memSeen !== 1'b0) $display("FAIL hit_no_write: got wr=%0d mem=%b want 0 0", o.wrCount, o.memSeen); else passCount++;
      checkCount++; if (o.readyAfter !== 1'b1 || o.respValidAfter !== 1'b0) $display("FAIL hit_release: got rdy=%b rv=%b want 1 0", o.readyAfter, o.respValidAfter); else passCount++;
   endtask

   task automatic test_miss_invalid();
      obs_t o;
      exp_t e;
      logic [29:0] a;
      a = 30'h1234_5678;
      expQ.push_back('{hit: 1'b0, way: 3'd3, wrCount: 1, tag: a[29:20], memAddr: a & ~30'h3F});
      applyStimulus(a, 1'b0, 3'd6, 8'b1111_0111, 0, 0, o);
      e = expQ.pop_front();
      checkCount++; if (o.timedOut !== 1'b0) $display("FAIL miss_timeout: no response within budget"); else passCount++;
      checkCount++; if (o.memAddr !== e.memAddr) $display("FAIL miss_mem_addr: got %h want %h", o.memAddr, e.memAddr); else passCount++;
      checkCount++; if (o.wrCount !== 1 || o.wrWay !== e.way || o.wrTag !== e.tag) $display("FAIL miss_write: got n=%0d way=%0d tag=%h want 1 %0d %h", o.wrCount, o.wrWay, o.wrTag, e.way, e.tag); else passCount++;
      checkCount++; if (o.hit !== e.hit || o.way !== e.way) $display("FAIL miss_resp: got h=%b w=%0d want h=%b w=%0d", o.hit, o.way, e.hit, e.way); else passCount++;
   endtask

   task automatic test_back_to_back();
      obs_t o;
      exp_t e;
      logic [29:0] a;
      for (int i = 0; i < 3; i++) begin
         a = 30'($urandom);
         expQ.push_back('{hit: 1'b1, way: 3'(i * 3 + 1), wrCount: 0, tag: a[29:20], memAddr: 30'd0});
         applyStimulus(a, 1'b1, 3'(i * 3 + 1), 8'hFF, 0, 0, o);
         e = expQ.pop_front();
         checkCount++; if (o.way !== e.way || o.hit !== e.hit || o.respCycle !== 3) $display("FAIL b2b_resp%0d: got h=%b w=%0d cyc=%0d want h=1 w=%0d cyc=3", i, o.hit, o.way, o.respCycle, e.way); else passCount++;
         checkCount++; if (o.readyAfter !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", i, o.readyAfter); else passCount++;
      end
   endtask

`ifdef LFSR_REPL_EN
   task automatic test_lfsr();
      obs_t o;
      exp_t e;
      logic [29:0] a;
      logic [15:0] s;
      for (int i = 0; i < 4; i++) begin
         a = 30'($urandom);
         @(negedge clock);
         s = refStep(refStep(refStep(refLfsr)));
         expQ.push_back('{hit: 1'b0, way: s[2:0], wrCount: 1, tag: a[29:20], memAddr: a & ~30'h3F});
         applyStimulus(a, 1'b0, 3'd0, 8'hFF, 0, 0, o);
         e = expQ.pop_front();
         checkCount++; if (o.way !== e.way || o.wrWay !== e.way || o.hit !== 1'b0) $display("FAIL lfsr_victim%0d: got w=%0d wr=%0d h=%b want %0d", i, o.way, o.wrWay, o.hit, e.way); else passCount++;
      end
   endtask
`else
   task automatic test_round_robin();
      obs_t o;
      exp_t e;
      logic [29:0] a;
      for (int i = 0; i < 12; i++) begin
         a = 30'($urandom);
         expQ.push_back('{hit: 1'b0, way: 3'(i % 8), wrCount: 1, tag: a[29:20], memAddr: a & ~30'h3F});
         applyStimulus(a, 1'b0, 3'd0, 8'hFF, 0, 0, o);
         e = expQ.pop_front();
         checkCount++; if (o.way !== e.way || o.wrWay !== e.way || o.hit !== 1'b0) $display("FAIL rr_victim%0d: got w=%0d wr=%0d h=%b want %0d", i, o.way, o.wrWay, o.hit, e.way); else passCount++;
         checkCount++; if (o.memAddr !== e.memAddr || o.wrTag !== e.tag) $display("FAIL rr_fill%0d: got addr=%h tag=%h want %h %h", i, o.memAddr, o.wrTag, e.memAddr, e.tag); else passCount++;
      end
   endtask
`endif

   task automatic test_stall();
      obs_t o;
      exp_t e;
      logic [29:0] a;
      a = 30'h3FFF_FFC5;
      expQ.push_back('{hit: 1'b0, way: 3'd7, wrCount: 1, tag: a[29:20], memAddr: a & ~30'h3F});
      applyStimulus(a, 1'b0, 3'd2, 8'h7F, 5, 4, o);
      e = expQ.pop_front();
      checkCount++; if (o.timedOut !== 1'b0) $display("FAIL stall_timeout: no response within budget"); else passCount++;
      checkCount++; if (o.memStable !== 1'b1 || o.memAddr !== e.memAddr) $display("FAIL stall_mem: got stable=%b addr=%h want 1 %h", o.memStable, o.memAddr, e.memAddr); else passCount++;
      checkCount++; if (o.respStable !== 1'b1 || o.way !== e.way || o.hit !== e.hit) $display("FAIL stall_resp: got stable=%b w=%0d h=%b want 1 %0d 0", o.respStable, o.way, o.hit, e.way); else passCount++;
      checkCount++; if (o.readyLowOk !== 1'b1) $display("FAIL stall_req_ready: got high while busy want low"); else passCount++;
      checkCount++; if (o.wrCount !== 1) $display("FAIL stall_write_count: got %0d want 1", o.wrCount); else passCount++;
   endtask

   task automatic test_reset_abort();
      bit found;
      int badCnt;
      @(negedge clock);
      req_valid = 1'b1;
      req_addr  = 30'h2468_ACE0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         req_valid = 1'b0;
         if (arr_rd_en === 1'b1) found = 1;
      end
      hd_hit = 1'b0;
      arr_valid = 8'h00;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         if (mem_req_valid === 1'b1) found = 1;
      end
      checkCount++; if (!found) $display("FAIL abort_reach_miss: got no mem_req_valid want 1"); else passCount++;
      mem_req_ready = 1'b1;
      @(negedge clock);
      mem_req_ready = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkCount++; if (req_ready !== 1'b1) $display("FAIL abort_req_ready: got %b want 1", req_ready); else passCount++;
      mem_fill_valid = 1'b1;
      @(negedge clock);
      mem_fill_valid = 1'b0;
      badCnt = 0;
      repeat (6) begin
         if (arr_wr_en !== 1'b0 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0) badCnt++;
         @(negedge clock);
      end
      checkCount++; if (badCnt !== 0) $display("FAIL abort_quiet: got %0d active cycles want 0", badCnt); else passCount++;
      checkCount++; if (req_ready !== 1'b1) $display("FAIL abort_idle: got req_ready=%b want 1", req_ready); else passCount++;
   endtask

   task automatic test_recovery();
      obs_t o;
      exp_t e;
      logic [29:0] a;
      a = 30'h0ABC_DEC0;
      expQ.push_back('{hit: 1'b1, way: 3'd2, wrCount: 0, tag: a[29:20], memAddr: 30'd0});
      applyStimulus(a, 1'b1, 3'd2, 8'hFF, 0, 0, o);
      e = expQ.pop_front();
      checkCount++; if (o.hit !== e.hit || o.way !== e.way || o.respCycle !== 3) $display("FAIL recovery_resp: got h=%b w=%0d cyc=%0d want 1 %0d 3", o.hit, o.way, o.respCycle, e.way); else passCount++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_hit();
      test_miss_invalid();
      test_back_to_back();
`ifdef LFSR_REPL_EN
      test_lfsr();
`else
      test_round_robin();
`endif
      test_stall();
      test_reset_abort();
      test_recovery();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
